// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: runs sequential 16-bit fetches from RAM2 ahead of
// decode into a small PC-tagged FIFO; a redirect flushes it and restarts fetch.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_pc,
    input  logic [15:0]              set_pc_addr,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_done,
    input  logic [15:0]              mem_data,
    output logic                     inst_valid,
    output logic [15:0]              inst,
    output logic [15:0]              inst_pc,
    input  logic                     inst_take,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   fpc_q, fpc_d;
    logic [15:0]   hold_addr_q, hold_addr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    logic [15:0]   pc_ram   [DEPTH];
    logic [15:0]   inst_ram [DEPTH];

    // A redirect overrides every other event; an open request is kept alive in
    // DISCARD so its late data can be swallowed instead of pushed.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        hold_addr_d = hold_addr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = inst_take && (count_q != '0);

        if (set_pc) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            fpc_d   = set_pc_addr;
            case (state_q)
                S_FETCH: begin
                    if (mem_done) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d     = S_DISCARD;
                        hold_addr_d = fpc_q;
                    end
                end
                S_DISCARD: state_d = mem_done ? S_FETCH : S_DISCARD;
                default:   state_d = S_FETCH;
            endcase
        end else begin
            push = (state_q == S_FETCH) && mem_done;
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
                fpc_d  = fpc_q + 16'd1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            case (state_q)
                S_IDLE: begin
                    if (count_d < CW'(DEPTH)) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (mem_done && (count_d == CW'(DEPTH))) state_d = S_IDLE;
                end
                S_DISCARD: begin
                    if (mem_done) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fpc_q       <= RESET_PC;
            hold_addr_q <= RESET_PC;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            hold_addr_q <= hold_addr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_ram[wptr_q]   <= fpc_q;
            inst_ram[wptr_q] <= mem_data;
        end
    end

    assign mem_req    = (state_q != S_IDLE);
    assign mem_addr   = (state_q == S_DISCARD) ? hold_addr_q : fpc_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? inst_ram[rptr_q] : 16'h0000;
    assign inst_pc    = inst_valid ? pc_ram[rptr_q] : 16'h0000;
    assign count      = count_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: a RAM model with selectable latency
// answers fetches with data = addr ^ 16'hA5A5; a second instance starts at 16'hFFFE.
module tb_inst_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_pc = 1'b0;
    logic [15:0] set_pc_addr = 16'h0000;
    logic        inst_take = 1'b0;
    logic        force_done = 1'b0;
    int          lat = 1;
    int          wait_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    logic        mem_req, mem_done, inst_valid;
    logic [15:0] mem_addr, mem_data, inst, inst_pc;
    logic [2:0]  count;

    logic        mem_req2, mem_done2, inst_valid2;
    logic [15:0] mem_addr2, mem_data2, inst2, inst_pc2;
    logic [2:0]  count2;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .set_pc(set_pc), .set_pc_addr(set_pc_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_take(inst_take), .count(count)
    );

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .set_pc(1'b0), .set_pc_addr(16'h0000),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_done(mem_done2), .mem_data(mem_data2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
        .inst_take(1'b1), .count(count2)
    );

    always #5 clk = ~clk;

    // RAM model: done arrives lat cycles after a request opens; force_done injects a stray pulse.
    assign mem_done  = force_done | (mem_req && (wait_cnt == lat - 1));
    assign mem_data  = mem_addr ^ 16'hA5A5;
    assign mem_done2 = mem_req2;
    assign mem_data2 = mem_addr2 ^ 16'hA5A5;

    always @(posedge clk) begin
        if (!mem_req || mem_done) wait_cnt <= 0;
        else                      wait_cnt <= wait_cnt + 1;
    end

    task automatic applyStimulus(input logic rst_v, input logic set_v,
                                 input logic [15:0] addr_v, input logic take_v);
        rst         = rst_v;
        set_pc      = set_v;
        set_pc_addr = addr_v;
        inst_take   = take_v;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset values
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        step();
        checkOutput("rst_mem_req",    {15'd0, mem_req},    16'h0000);
        checkOutput("rst_mem_addr",   mem_addr,            16'h0000);
        checkOutput("rst_inst_valid", {15'd0, inst_valid}, 16'h0000);
        checkOutput("rst_inst",       inst,                16'h0000);
        checkOutput("rst_inst_pc",    inst_pc,             16'h0000);
        checkOutput("rst_count",      {13'd0, count},      16'h0000);
        checkOutput("rst2_mem_addr",  mem_addr2,           16'hFFFE);
        checkOutput("rst2_count",     {13'd0, count2},     16'h0000);

        // Streaming at 1-cycle latency with a consumer that always takes
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        step();
        checkOutput("s1_mem_req",    {15'd0, mem_req},    16'h0001);
        checkOutput("s1_mem_addr",   mem_addr,            16'h0000);
        checkOutput("s1_inst_valid", {15'd0, inst_valid}, 16'h0000);
        step();
        checkOutput("s2_inst_pc",    inst_pc,             16'h0000);
        checkOutput("s2_inst",       inst,                16'hA5A5);
        checkOutput("s2_count",      {13'd0, count},      16'h0001);
        checkOutput("s2_mem_addr",   mem_addr,            16'h0001);
        checkOutput("s2_pc_wrap",    inst_pc2,            16'hFFFE);
        step();
        checkOutput("s3_inst_pc",    inst_pc,             16'h0001);
        checkOutput("s3_count",      {13'd0, count},      16'h0001);
        checkOutput("s3_mem_addr",   mem_addr,            16'h0002);
        checkOutput("s3_pc_wrap",    inst_pc2,            16'hFFFF);
        step();
        checkOutput("s4_inst_pc",    inst_pc,             16'h0002);
        checkOutput("s4_pc_wrap",    inst_pc2,            16'h0000);
        step();
        checkOutput("s5_inst_pc",    inst_pc,             16'h0003);
        checkOutput("s5_pc_wrap",    inst_pc2,            16'h0001);
        checkOutput("s5_inst_wrap",  inst2,               16'hA5A4);

        // Redirect coinciding with mem_done and inst_take
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b1);
        step();
        checkOutput("rd_count",      {13'd0, count},      16'h0000);
        checkOutput("rd_inst_valid", {15'd0, inst_valid}, 16'h0000);
        checkOutput("rd_inst_pc",    inst_pc,             16'h0000);
        checkOutput("rd_mem_req",    {15'd0, mem_req},    16'h0001);
        checkOutput("rd_mem_addr",   mem_addr,            16'h0000);

        // Fill without a consumer: four pushes then idle
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        checkOutput("f1_count",      {13'd0, count},      16'h0001);
        step();
        step();
        checkOutput("f3_count",      {13'd0, count},      16'h0003);
        step();
        checkOutput("f4_count",      {13'd0, count},      16'h0004);
        checkOutput("f4_mem_req",    {15'd0, mem_req},    16'h0000);
        step();
        checkOutput("f5_count",      {13'd0, count},      16'h0004);
        checkOutput("f5_mem_req",    {15'd0, mem_req},    16'h0000);
        checkOutput("f5_inst_pc",    inst_pc,             16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        step();
        checkOutput("p1_count",      {13'd0, count},      16'h0003);
        checkOutput("p1_mem_req",    {15'd0, mem_req},    16'h0001);
        checkOutput("p1_mem_addr",   mem_addr,            16'h0004);
        checkOutput("p1_inst_pc",    inst_pc,             16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        checkOutput("p2_count",      {13'd0, count},      16'h0004);
        checkOutput("p2_mem_req",    {15'd0, mem_req},    16'h0000);

        // Latency 3: redirect one cycle after the request to 0x0005 opens
        lat = 3;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        step();
        checkOutput("l1_mem_addr",   mem_addr,            16'h0005);
        checkOutput("l1_mem_req",    {15'd0, mem_req},    16'h0001);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b0);
        step();
        checkOutput("l2_count",      {13'd0, count},      16'h0000);
        checkOutput("l2_inst_valid", {15'd0, inst_valid}, 16'h0000);
        checkOutput("l2_mem_addr",   mem_addr,            16'h0005);
        checkOutput("l2_mem_req",    {15'd0, mem_req},    16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        checkOutput("l3_mem_addr",   mem_addr,            16'h0005);
        checkOutput("l3_mem_done",   {15'd0, mem_done},   16'h0001);
        step();
        checkOutput("l4_mem_addr",   mem_addr,            16'h0100);
        checkOutput("l4_inst_valid", {15'd0, inst_valid}, 16'h0000);
        step();
        step();
        checkOutput("l6_inst_valid", {15'd0, inst_valid}, 16'h0000);
        step();
        checkOutput("l7_inst_valid", {15'd0, inst_valid}, 16'h0001);
        checkOutput("l7_inst_pc",    inst_pc,             16'h0100);
        checkOutput("l7_inst",       inst,                16'hA4A5);
        checkOutput("l7_count",      {13'd0, count},      16'h0001);

        // Reset while in DISCARD with a stray mem_done during reset
        applyStimulus(1'b1, 1'b1, 16'h0200, 1'b0);
        step();
        checkOutput("d1_mem_addr",   mem_addr,            16'h0101);
        checkOutput("d1_count",      {13'd0, count},      16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        force_done = 1'b1;
        step();
        checkOutput("d2_mem_req",    {15'd0, mem_req},    16'h0000);
        checkOutput("d2_mem_addr",   mem_addr,            16'h0000);
        checkOutput("d2_count",      {13'd0, count},      16'h0000);
        checkOutput("d2_inst_valid", {15'd0, inst_valid}, 16'h0000);
        checkOutput("d2_inst_pc",    inst_pc,             16'h0000);
        step();
        force_done = 1'b0;
        lat = 1;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        checkOutput("d3_mem_req",    {15'd0, mem_req},    16'h0001);
        checkOutput("d3_mem_addr",   mem_addr,            16'h0000);
        step();
        checkOutput("d4_inst_pc",    inst_pc,             16'h0000);
        checkOutput("d4_count",      {13'd0, count},      16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue between the RAM2 instruction-fetch port and the IF/ID pipeline register. Runs ahead of decode, fetching sequential 16-bit instructions into a small FIFO tagged with their PC, so RAM2 latency is hidden from the pipeline. A taken branch or jump (`set_pc`) flushes the queue and restarts fetch at the target, discarding any in-flight fetch.

## Interface

Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `RESET_PC`, 16'h0000: first fetch address after reset.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `set_pc`  in  1  redirect request from jump control.
- `set_pc_addr`  in  16  redirect target.
- `mem_req`  out  1  fetch request to RAM2 IF port.
- `mem_addr`  out  16  fetch address; stable while `mem_req` is high and `mem_done` not yet seen.
- `mem_done`  in  1  one-cycle pulse: `mem_data` valid for the current request.
- `mem_data`  in  16  fetched instruction word.
- `inst_valid`  out  1  queue head holds a valid instruction.
- `inst`  out  16  head instruction.
- `inst_pc`  out  16  head instruction's PC.
- `inst_take`  in  1  consumer pops head this cycle; ignored when `inst_valid` is 0.
- `count`  out  log2(DEPTH)+1  occupied entries.

## Operation

- Storage: DEPTH entries of {pc[15:0], inst[15:0]}, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus occupancy counter.
- `inst`/`inst_pc` driven from the head entry; `inst_valid` = (`count` != 0). Outputs are 0 when empty.
- Fetch PC register `fpc`: address of the next/current request; increments by 1 modulo 2^16 (16'hFFFF -> 16'h0000) on each accepted `mem_done` in FETCH.
- FSM states:
  - IDLE: `mem_req`=0. Go to FETCH when `count` < DEPTH (after this cycle's pop).
  - FETCH: `mem_req`=1, `mem_addr`=`fpc`. On `mem_done`: push {`fpc`, `mem_data`}, `fpc`+1; stay in FETCH if post-update `count` < DEPTH, else go to IDLE.
  - DISCARD: `mem_req`=1, `mem_addr` held at the abandoned address. On `mem_done`: drop data, go to FETCH with `fpc` = latched redirect target.
- Redirect (`set_pc`=1), in every state:
  - Queue flushed (pointers and `count` to 0).
  - `fpc` <= `set_pc_addr`.
  - From IDLE: go to FETCH.
  - From FETCH without `mem_done` this cycle: go to DISCARD; the request stays open until its `mem_done` arrives.
  - From FETCH with `mem_done` this cycle: data dropped, go to FETCH at the new `fpc`.
  - From DISCARD: target re-latched, stay in DISCARD unless `mem_done`, which goes to FETCH at the new target.
- Simultaneous events:
  - `set_pc` beats `inst_take` and `mem_done`.
  - Push and pop in the same cycle: `count` unchanged.
  - One request outstanding at most, and a request is issued only with a free slot, so a push never overflows.
  - `inst_take` when empty: no effect.

## Timing

- During reset: `mem_req`=0, `mem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `count`=0, state IDLE, `fpc`=RESET_PC.
- First edge with `rst`=1: IDLE -> FETCH; `mem_req` high from that cycle.
- `mem_done` sampled at edge N: entry visible (`inst_valid`=1, `count` incremented) after edge N. The next request's address appears after the same edge, so back-to-back single-cycle-latency fetches sustain 1 instruction per cycle.
- `set_pc` at edge N: `inst_valid`=0 after edge N. The first target instruction appears no earlier than one `mem_done` later (or after two `mem_done` when in DISCARD).
- Reset asserted mid-fetch: state, queue and `fpc` reinitialize at that edge; any later `mem_done` is ignored while in IDLE.

## Test plan

- Reset, RAM model with 1-cycle latency, `inst_take` held 1: requests 0x0000, 0x0001, 0x0002… in consecutive cycles; head PCs appear in order, one per cycle.
- `inst_take`=0, DEPTH=4: exactly 4 pushes, then `mem_req`=0 and `count`=4. Pulse `inst_take` once: `count`=3, then exactly one new request to 0x0004.
- RAM latency 3, `set_pc`=1 with `set_pc_addr`=0x0100 one cycle after a request to 0x0005 issues: queue empties, 0x0005 stays requested until `mem_done` and its data is never output, then a request to 0x0100 follows; the first head is PC 0x0100.
- `set_pc` coinciding with `mem_done` and `inst_take`: fetched word dropped, `count`=0, next request to the target.
- `RESET_PC`=16'hFFFE, free-running consumer: head PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `rst` low while in DISCARD, with `mem_done` arriving during reset: all outputs at reset values; the first request after release is to RESET_PC.
